// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/retire slice: ALU op codes, major
// opcodes and branch funct3 values, plus the funct3 -> op code map.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // funct3 map shared by OP and OP-IMM; funct7_5 only selects sub for the
  // register form, and always selects sra for right shifts.
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3,
                                                     input logic       funct7_5,
                                                     input logic       is_reg);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational decode of instruction fields into ALU op code and operands.
// Branch decode is present only when ALU_ISSUE_BRANCH_EN is defined.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7_5_i,
  input  logic [Width-1:0] rs1_i,
  input  logic [Width-1:0] rs2_i,
  input  logic [Width-1:0] imm_i,
  output logic [3:0]       control_o,
  output logic [Width-1:0] a1_o,
  output logic [Width-1:0] a2_o,
  output logic             is_branch_o,
  output logic             illegal_o,
  output logic [2:0]       funct3_o
);

  // Field decode; illegal encodings are forced to add with zero operands.
  always_comb begin
    control_o   = ALU_ADD;
    a1_o        = '0;
    a2_o        = '0;
    is_branch_o = 1'b0;
    illegal_o   = 1'b0;
    funct3_o    = funct3_i;
    case (opcode_i)
      OPC_OP: begin
        control_o = alu_op_from_funct3(funct3_i, funct7_5_i, 1'b1);
        a1_o      = rs1_i;
        a2_o      = rs2_i;
      end
      OPC_OPIMM: begin
        control_o = alu_op_from_funct3(funct3_i, funct7_5_i, 1'b0);
        a1_o      = rs1_i;
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          a2_o = {{(Width-5){1'b0}}, imm_i[4:0]};
        end else begin
          a2_o = imm_i;
        end
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        if (funct3_i == 3'b010 || funct3_i == 3'b011) begin
          illegal_o = 1'b1;
        end else begin
          control_o   = ALU_SUB;
          a1_o        = rs1_i;
          a2_o        = rs2_i;
          is_branch_o = 1'b1;
        end
      end
`endif
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      control_o   = ALU_ADD;
      a1_o        = '0;
      a2_o        = '0;
      is_branch_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue/retire wrapper around a single-cycle ALU.
// Optional macro ALU_ISSUE_BRANCH_EN enables branch decode and resolution.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [Width-1:0] in_rs1,
  input  logic [Width-1:0] in_rs2,
  input  logic [Width-1:0] in_imm,
  output logic [3:0]       alu_control,
  output logic [Width-1:0] alu_a1,
  output logic [Width-1:0] alu_a2,
  input  logic [Width-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             alu_s_less,
  input  logic             alu_u_less,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_result,
  output logic             out_branch,
  output logic             out_taken,
  output logic             out_illegal
);

  logic [3:0]       enc_control;
  logic [Width-1:0] enc_a1, enc_a2;
  logic             enc_branch, enc_illegal;
  logic [2:0]       enc_funct3;

  alu_op_encoder #(.Width(Width)) u_enc (
    .opcode_i    (in_opcode),
    .funct3_i    (in_funct3),
    .funct7_5_i  (in_funct7_5),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .imm_i       (in_imm),
    .control_o   (enc_control),
    .a1_o        (enc_a1),
    .a2_o        (enc_a2),
    .is_branch_o (enc_branch),
    .illegal_o   (enc_illegal),
    .funct3_o    (enc_funct3)
  );

  logic             iss_valid_q, iss_valid_d;
  logic [3:0]       iss_control_q;
  logic [Width-1:0] iss_a1_q, iss_a2_q;
  logic             iss_branch_q, iss_illegal_q;
  logic [2:0]       iss_funct3_q;

  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_result_q;
  logic             out_branch_q, out_taken_q, out_illegal_q;

  logic iss_load, out_load, taken;

  // Handshake: the output stage drains into the consumer while the issue
  // stage refills in the same cycle, so in_ready looks through out_load.
  always_comb begin
    out_load    = iss_valid_q && (!out_valid_q || out_ready);
    in_ready    = !iss_valid_q || out_load;
    iss_load    = in_valid && in_ready;
    iss_valid_d = iss_load ? 1'b1 : (out_load ? 1'b0 : iss_valid_q);
    out_valid_d = out_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end

`ifdef ALU_ISSUE_BRANCH_EN
  // Branch condition from ALU flags of the issued subtract.
  always_comb begin
    taken = 1'b0;
    case (iss_funct3_q)
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLT:  taken = alu_s_less;
      BR_BGE:  taken = !alu_s_less;
      BR_BLTU: taken = alu_u_less;
      BR_BGEU: taken = !alu_u_less;
      default: taken = 1'b0;
    endcase
    taken = taken && iss_branch_q;
  end
`else
  logic unused_branch;
  assign unused_branch = ^{alu_zero, alu_s_less, alu_u_less, iss_funct3_q, iss_branch_q};
  assign taken = 1'b0;
`endif

  // Issue stage register; ALU ports hold their last values while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid_q   <= 1'b0;
      iss_control_q <= ALU_ADD;
      iss_a1_q      <= '0;
      iss_a2_q      <= '0;
      iss_branch_q  <= 1'b0;
      iss_illegal_q <= 1'b0;
      iss_funct3_q  <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      if (iss_load) begin
        iss_control_q <= enc_control;
        iss_a1_q      <= enc_a1;
        iss_a2_q      <= enc_a2;
        iss_branch_q  <= enc_branch;
        iss_illegal_q <= enc_illegal;
        iss_funct3_q  <= enc_funct3;
      end
    end
  end

  // Retire stage register; captures ALU result and flags only on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_branch_q  <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (out_load) begin
        out_result_q  <= iss_illegal_q ? '0 : alu_y;
        out_branch_q  <= iss_branch_q;
        out_taken_q   <= taken;
        out_illegal_q <= iss_illegal_q;
      end
    end
  end

  assign alu_control = iss_control_q;
  assign alu_a1      = iss_a1_q;
  assign alu_a2      = iss_a2_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_illegal = out_illegal_q;
`ifdef ALU_ISSUE_BRANCH_EN
  assign out_branch  = out_branch_q;
  assign out_taken   = out_taken_q;
`else
  logic unused_out;
  assign unused_out  = out_branch_q ^ out_taken_q;
  assign out_branch  = 1'b0;
  assign out_taken   = 1'b0;
`endif

endmodule
